cmd_credit_arbiter_n: RTL and testbench

- Parametrised successor to the fixed six-buffer command arbitration of the AFU-Control path.
- Arbitrates NUM_CH command channels (restart, wed, write, read, prefetch-write, prefetch-read, plus extras) onto the single PSL command port.
- Tracks separate read and write credit pools, and adds selectable fixed-priority or round-robin mode.
- Adds starvation aging: long-waiting channels are promoted to urgent.

---
 rtl/cmd_credit_arbiter_n_pkg.sv | 20 ++
 rtl/cmd_credit_arbiter_n_credit_pool.sv | 41 ++++
 rtl/cmd_credit_arbiter_n.sv | 173 +++++++++++++++++
 tb/tb_cmd_credit_arbiter_n.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_credit_arbiter_n_pkg.sv
// Shared AFU command-arbitration constants: channel ordering, default sizes and arbitration mode type.
package cmd_credit_arbiter_n_pkg;

    localparam int unsigned NUM_CMD_CH_GLOBAL = 6;
    localparam int unsigned ARB_STARVE_LIMIT  = 48;

    // Channel indices follow the legacy PRIORITY_* ordering, highest priority first.
    localparam int unsigned CH_RESTART        = 0;
    localparam int unsigned CH_WED            = 1;
    localparam int unsigned CH_WRITE          = 2;
    localparam int unsigned CH_READ           = 3;
    localparam int unsigned CH_PREFETCH_WRITE = 4;
    localparam int unsigned CH_PREFETCH_READ  = 5;

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_t;

endpackage

// File: rtl/cmd_credit_arbiter_n_credit_pool.sv
// Saturating up/down credit counter; flags a return that arrives while the pool is already full.
module cmd_credit_arbiter_n_credit_pool
    import cmd_credit_arbiter_n_pkg::*;
#(
    parameter  int unsigned MAX_CREDITS = 32,
    localparam int unsigned CNT_W       = $clog2(MAX_CREDITS + 1)
) (
    input  logic             clock_i,
    input  logic             rst_i,
    input  logic             take_i,
    input  logic             give_i,
    output logic [CNT_W-1:0] count_o,
    output logic             overflow_c_o
);

    localparam logic [CNT_W-1:0] FULL = CNT_W'(MAX_CREDITS);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (take_i && !give_i) begin
            count_d = count_q - CNT_W'(1);
        end else if (give_i && !take_i && (count_q != FULL)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock_i) begin
        if (rst_i) begin
            count_q <= FULL;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o      = count_q;
    assign overflow_c_o = give_i && (count_q == FULL);

endmodule

// File: rtl/cmd_credit_arbiter_n.sv
// Credit-gated command arbiter: NUM_CH requesters onto one PSL command port with
// fixed-priority or round-robin selection and starvation promotion.
module cmd_credit_arbiter_n
    import cmd_credit_arbiter_n_pkg::*;
#(
    parameter int unsigned NUM_CH        = NUM_CMD_CH_GLOBAL,
    parameter int unsigned CREDITS_READ  = 32,
    parameter int unsigned CREDITS_WRITE = 32,
    parameter int unsigned AGE_W         = 6,
    parameter int unsigned STARVE_LIMIT  = ARB_STARVE_LIMIT
) (
    input  logic                                clock_i,
    input  logic                                rst_i,
    input  logic                                enable_i,
    input  logic                                arb_mode_i,
    input  logic [NUM_CH-1:0]                   req_valid_i,
    input  logic [NUM_CH-1:0]                   req_is_write_i,
    output logic [NUM_CH-1:0]                   grant_o,
    output logic                                cmd_valid_o,
    output logic [$clog2(NUM_CH)-1:0]           cmd_ch_o,
    output logic                                cmd_is_write_o,
    input  logic                                rsp_valid_i,
    input  logic                                rsp_is_write_i,
    output logic [$clog2(CREDITS_READ+1)-1:0]   credits_read_avail_o,
    output logic [$clog2(CREDITS_WRITE+1)-1:0]  credits_write_avail_o,
    output logic                                credit_error_o
);

    localparam int unsigned      CH_W    = $clog2(NUM_CH);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STARVE_LIMIT);

    if (CREDITS_READ + CREDITS_WRITE > 64) begin : g_credit_budget
        $error("CREDITS_READ + CREDITS_WRITE must not exceed 64");
    end
    if (STARVE_LIMIT >= (1 << AGE_W)) begin : g_age_range
        $error("STARVE_LIMIT must fit in AGE_W bits");
    end

    logic [NUM_CH-1:0] req_q;
    logic [NUM_CH-1:0] isw_q;
    logic              en_q;
    arb_mode_t         mode_q;
    logic [NUM_CH-1:0] grant_q;
    logic              cmd_valid_q;
    logic [CH_W-1:0]   cmd_ch_q;
    logic              cmd_is_write_q;
    logic              credit_error_q;
    logic [CH_W-1:0]   rr_q;
    logic [CH_W-1:0]   rr_d;
    logic [AGE_W-1:0]  age_q [NUM_CH];
    logic [AGE_W-1:0]  age_d [NUM_CH];

    logic [NUM_CH-1:0] elig_c;
    logic [NUM_CH-1:0] urgent_c;
    logic [NUM_CH-1:0] rot_c;
    logic [NUM_CH-1:0] grant_d;
    logic [CH_W-1:0]   win_c;
    logic              win_found_c;
    logic              issue_rd_c;
    logic              issue_wr_c;
    logic              ovf_rd_c;
    logic              ovf_wr_c;
    logic [$clog2(CREDITS_READ+1)-1:0]  cnt_rd;
    logic [$clog2(CREDITS_WRITE+1)-1:0] cnt_wr;

    // Eligibility from registered state only; last cycle's winner is masked.
    always_comb begin
        elig_c   = '0;
        urgent_c = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            elig_c[i]   = en_q && req_q[i] && !grant_q[i]
                          && (isw_q[i] ? (cnt_wr != '0) : (cnt_rd != '0));
            urgent_c[i] = elig_c[i] && (age_q[i] == AGE_MAX);
        end
    end

    always_comb begin
        win_c = '0;
        rot_c = NUM_CH'({elig_c, elig_c} >> rr_q);
        if (|urgent_c) begin
            for (int i = NUM_CH - 1; i >= 0; i--) begin
                if (urgent_c[i]) win_c = CH_W'(i);
            end
        end else if (mode_q == ARB_FIXED) begin
            for (int i = NUM_CH - 1; i >= 0; i--) begin
                if (elig_c[i]) win_c = CH_W'(i);
            end
        end else begin
            // rot_c[k] is channel (rr_q + k) mod NUM_CH; smallest k wins.
            for (int k = NUM_CH - 1; k >= 0; k--) begin
                if (rot_c[k]) win_c = CH_W'((int'(rr_q) + k) % NUM_CH);
            end
        end
        win_found_c = |elig_c;
        grant_d     = win_found_c ? (NUM_CH'(1) << win_c) : '0;
        issue_wr_c  = |(grant_d & isw_q);
        issue_rd_c  = |(grant_d & ~isw_q);
        rr_d        = rr_q;
        if (win_found_c) begin
            rr_d = (win_c == CH_W'(NUM_CH - 1)) ? '0 : win_c + CH_W'(1);
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            age_d[i] = age_q[i];
            if (en_q) begin
                if (!req_q[i] || grant_d[i]) begin
                    age_d[i] = '0;
                end else if (age_q[i] != AGE_MAX) begin
                    age_d[i] = age_q[i] + AGE_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (rst_i) begin
            req_q          <= '0;
            isw_q          <= '0;
            en_q           <= 1'b0;
            mode_q         <= ARB_FIXED;
            grant_q        <= '0;
            cmd_valid_q    <= 1'b0;
            cmd_ch_q       <= '0;
            cmd_is_write_q <= 1'b0;
            credit_error_q <= 1'b0;
            rr_q           <= '0;
            for (int i = 0; i < NUM_CH; i++) age_q[i] <= '0;
        end else begin
            req_q          <= req_valid_i;
            isw_q          <= req_is_write_i;
            en_q           <= enable_i;
            mode_q         <= arb_mode_t'(arb_mode_i);
            grant_q        <= grant_d;
            cmd_valid_q    <= win_found_c;
            credit_error_q <= credit_error_q | ovf_rd_c | ovf_wr_c;
            rr_q           <= rr_d;
            if (win_found_c) begin
                cmd_ch_q       <= win_c;
                cmd_is_write_q <= issue_wr_c;
            end
            for (int i = 0; i < NUM_CH; i++) age_q[i] <= age_d[i];
        end
    end

    cmd_credit_arbiter_n_credit_pool #(.MAX_CREDITS(CREDITS_READ)) u_pool_rd (
        .clock_i      (clock_i),
        .rst_i        (rst_i),
        .take_i       (issue_rd_c),
        .give_i       (rsp_valid_i && !rsp_is_write_i),
        .count_o      (cnt_rd),
        .overflow_c_o (ovf_rd_c)
    );

    cmd_credit_arbiter_n_credit_pool #(.MAX_CREDITS(CREDITS_WRITE)) u_pool_wr (
        .clock_i      (clock_i),
        .rst_i        (rst_i),
        .take_i       (issue_wr_c),
        .give_i       (rsp_valid_i && rsp_is_write_i),
        .count_o      (cnt_wr),
        .overflow_c_o (ovf_wr_c)
    );

    assign grant_o               = grant_q;
    assign cmd_valid_o           = cmd_valid_q;
    assign cmd_ch_o              = cmd_ch_q;
    assign cmd_is_write_o        = cmd_is_write_q;
    assign credits_read_avail_o  = cnt_rd;
    assign credits_write_avail_o = cnt_wr;
    assign credit_error_o        = credit_error_q;

endmodule

// File: tb/tb_cmd_credit_arbiter_n.sv
// Bench for cmd_credit_arbiter_n: directed scenarios plus random traffic against a behavioural model.
module tb_cmd_credit_arbiter_n;
    import cmd_credit_arbiter_n_pkg::*;

    localparam int NCH = 6;
    localparam int CR  = 32;
    localparam int CW  = 32;
    localparam int LIM = 48;

    logic       clock;
    logic       rst, enable, arb_mode, rsp_valid, rsp_is_write;
    logic [5:0] req_valid, req_is_write, grant;
    logic       cmd_valid, cmd_is_write, credit_error;
    logic [2:0] cmd_ch;
    logic [5:0] cr_avail, cw_avail;

    logic       s_rst, s_en, s_mode, s_rsp_v, s_rsp_w;
    logic [5:0] s_req, s_isw, s_grant;
    logic       s_cmd_valid, s_cmd_is_write, s_err;
    logic [2:0] s_cmd_ch;
    logic [5:0] s_cr, s_cw;

    int checks;
    int errors;

    // Reference model state: what the arbiter has sampled and what it has committed.
    int       m_cr, m_cw, m_rr, m_grant, m_ch;
    bit       m_err, m_cv, m_lw, m_en, m_mode;
    int       m_age [NCH];
    bit [5:0] m_req, m_isw;

    cmd_credit_arbiter_n dut (
        .clock_i(clock), .rst_i(rst), .enable_i(enable), .arb_mode_i(arb_mode),
        .req_valid_i(req_valid), .req_is_write_i(req_is_write), .grant_o(grant),
        .cmd_valid_o(cmd_valid), .cmd_ch_o(cmd_ch), .cmd_is_write_o(cmd_is_write),
        .rsp_valid_i(rsp_valid), .rsp_is_write_i(rsp_is_write),
        .credits_read_avail_o(cr_avail), .credits_write_avail_o(cw_avail),
        .credit_error_o(credit_error)
    );

    cmd_credit_arbiter_n #(.STARVE_LIMIT(4)) dut_s (
        .clock_i(clock), .rst_i(s_rst), .enable_i(s_en), .arb_mode_i(s_mode),
        .req_valid_i(s_req), .req_is_write_i(s_isw), .grant_o(s_grant),
        .cmd_valid_o(s_cmd_valid), .cmd_ch_o(s_cmd_ch), .cmd_is_write_o(s_cmd_is_write),
        .rsp_valid_i(s_rsp_v), .rsp_is_write_i(s_rsp_w),
        .credits_read_avail_o(s_cr), .credits_write_avail_o(s_cw),
        .credit_error_o(s_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit eligible(input int i);
        return m_en && m_req[i] && (m_grant != i) && (m_isw[i] ? (m_cw > 0) : (m_cr > 0));
    endfunction

    // One clock of the specification's rules applied to the currently driven inputs.
    task automatic model_step();
        int win;
        bit ret_r, ret_w;
        if (rst) begin
            m_cr = CR; m_cw = CW; m_err = 0; m_rr = 0; m_grant = -1;
            m_cv = 0; m_ch = 0; m_lw = 0; m_req = '0; m_isw = '0; m_en = 0; m_mode = 0;
            for (int i = 0; i < NCH; i++) m_age[i] = 0;
            return;
        end
        win = -1;
        for (int i = 0; i < NCH; i++)
            if (win < 0 && eligible(i) && m_age[i] == LIM) win = i;
        for (int k = 0; k < NCH; k++) begin
            int c;
            c = m_mode ? (m_rr + k) % NCH : k;
            if (win < 0 && eligible(c)) win = c;
        end
        ret_r = rsp_valid && !rsp_is_write;
        ret_w = rsp_valid && rsp_is_write;
        if (ret_r && m_cr == CR) m_err = 1;
        if (ret_w && m_cw == CW) m_err = 1;
        if (win >= 0) begin
            if (m_isw[win]) m_cw--;
            else m_cr--;
        end
        if (ret_r) m_cr = (m_cr + 1 > CR) ? CR : m_cr + 1;
        if (ret_w) m_cw = (m_cw + 1 > CW) ? CW : m_cw + 1;
        if (m_en)
            for (int i = 0; i < NCH; i++)
                m_age[i] = (!m_req[i] || i == win) ? 0 : ((m_age[i] + 1 > LIM) ? LIM : m_age[i] + 1);
        if (win >= 0) begin
            m_rr = (win + 1) % NCH;
            m_ch = win;
            m_lw = m_isw[win];
        end
        m_grant = win;
        m_cv    = (win >= 0);
        m_req   = req_valid;
        m_isw   = req_is_write;
        m_en    = enable;
        m_mode  = arb_mode;
    endtask

    task automatic check_all();
        logic [5:0] eg;
        eg = (m_grant >= 0) ? 6'(1 << m_grant) : 6'd0;
        chk("grant", grant, eg);
        chk("cmd_valid", cmd_valid, m_cv);
        chk("cmd_ch", cmd_ch, m_ch);
        chk("cmd_is_write", cmd_is_write, m_lw);
        chk("credits_read", cr_avail, m_cr);
        chk("credits_write", cw_avail, m_cw);
        chk("credit_error", credit_error, m_err);
    endtask

    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
        check_all();
    endtask

    initial begin
        int exp_s [6];
        int exp_order [6];
        int order [6];
        int n, lat;
        bit got0, inj, done5;
        logic [5:0] eg;

        checks = 0; errors = 0;
        rst = 1; enable = 0; arb_mode = 0; req_valid = '0; req_is_write = '0;
        rsp_valid = 0; rsp_is_write = 0;
        s_rst = 1; s_en = 0; s_mode = 0; s_req = '0; s_isw = '0; s_rsp_v = 0; s_rsp_w = 0;

        // Starvation on the short-limit instance: ch0/ch1 alternate while ch5 waits.
        exp_s = '{-1, 0, 1, 0, 1, 5};
        repeat (2) @(posedge clock);
        #1;
        s_rst = 0; s_en = 1; s_req = 6'b100011;
        for (int e = 0; e < 6; e++) begin
            @(posedge clock);
            #1;
            eg = (exp_s[e] >= 0) ? 6'(1 << exp_s[e]) : 6'd0;
            chk("starve_grant", s_grant, eg);
            chk("starve_valid", s_cmd_valid, exp_s[e] >= 0);
        end
        chk("starve_ch", s_cmd_ch, 5);
        chk("starve_age_clear", dut_s.age_q[5], 0);
        chk("starve_credits_rd", s_cr, 27);
        chk("starve_credits_wr", s_cw, 32);
        chk("starve_is_write", s_cmd_is_write, 0);
        chk("starve_err", s_err, 0);
        s_req = '0;

        // Reset values.
        tick();
        chk("rst_grant", grant, 0);
        chk("rst_credits_rd", cr_avail, 32);
        tick();
        rst = 0;
        tick();

        // Fixed priority, all six channels reading.
        exp_order = '{CH_RESTART, CH_WED, CH_WRITE, CH_READ, CH_PREFETCH_WRITE, CH_PREFETCH_READ};
        enable = 1; arb_mode = 0; req_valid = 6'h3F; req_is_write = '0; n = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (m_cv) begin
                if (n < 6) order[n] = m_ch;
                n++;
                req_valid[m_ch] = 1'b0;
            end
        end
        chk("fixed_count", n, 6);
        for (int k = 0; k < 6; k++) chk("fixed_order", order[k], exp_order[k]);
        chk("fixed_credits", cr_avail, 26);

        // Round-robin between ch1 and ch4 with a return every cycle; then ch0 joins.
        arb_mode = 1; req_valid = 6'b010010; rsp_valid = 1; rsp_is_write = 0;
        repeat (6) tick();
        req_valid[0] = 1'b1; lat = 0; got0 = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (!got0) begin
                lat++;
                if (cmd_valid && grant[0]) begin
                    got0 = 1;
                    req_valid[0] = 1'b0;
                end
            end
        end
        chk("rr_ch0_latency_ok", got0 && lat <= 3, 1);
        rsp_valid = 0; req_valid = '0;

        // Credit exhaustion with a same-cycle issue/return at count 5.
        rst = 1; tick(); rst = 0; tick();
        arb_mode = 0; req_valid = 6'b001100; req_is_write = '0; done5 = 0;
        for (int c = 0; c < 50; c++) begin
            inj = (m_cr == 5) && !done5;
            rsp_valid = inj; rsp_is_write = 0;
            tick();
            if (inj) begin
                done5 = 1;
                chk("cnt5_hold", cr_avail, 5);
                chk("cnt5_issue", cmd_valid, 1);
            end
        end
        rsp_valid = 0;
        chk("cnt5_seen", done5, 1);
        chk("exhaust_credits", cr_avail, 0);
        chk("exhaust_no_grant", cmd_valid, 0);
        rsp_valid = 1; tick(); rsp_valid = 0;
        chk("ret_cycle_no_grant", cmd_valid, 0);
        tick();
        chk("ret_grant_2cyc", cmd_valid, 1);
        chk("ret_credits_zero", cr_avail, 0);
        req_valid = '0;

        // Return into a full pool sets a sticky error.
        rst = 1; tick(); rst = 0; tick();
        rsp_valid = 1; rsp_is_write = 0; tick(); rsp_valid = 0;
        chk("ovf_err", credit_error, 1);
        chk("ovf_credits", cr_avail, 32);
        repeat (5) tick();
        chk("ovf_sticky", credit_error, 1);
        rst = 1; tick();
        chk("ovf_rst_clear", credit_error, 0);

        // Reset mid-operation with cmd_valid=1 and 10 read credits left.
        rst = 0; tick();
        req_valid = 6'b001100;
        for (int c = 0; c < 40; c++) begin
            if (m_cr == 10 && m_cv) break;
            tick();
        end
        chk("mid_pre_valid", cmd_valid, 1);
        chk("mid_pre_credits", cr_avail, 10);
        rst = 1; tick();
        chk("mid_grant", grant, 0);
        chk("mid_valid", cmd_valid, 0);
        chk("mid_ch", cmd_ch, 0);
        chk("mid_is_write", cmd_is_write, 0);
        chk("mid_credits_rd", cr_avail, 32);
        chk("mid_credits_wr", cw_avail, 32);
        rst = 0; tick();
        chk("mid_no_grant_after_rst", cmd_valid, 0);
        tick();
        req_valid = '0;

        // Random traffic against the model.
        rst = 1; tick(); rst = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NCH; i++) begin
                if (req_valid[i] && m_cv && m_ch == i) begin
                    if ($urandom_range(3) != 0) req_valid[i] = 1'b0;
                end else if (!req_valid[i] && $urandom_range(4) == 0) begin
                    req_valid[i]    = 1'b1;
                    req_is_write[i] = 1'($urandom_range(1));
                end
            end
            rsp_valid    = ($urandom_range(7) < 3);
            rsp_is_write = 1'($urandom_range(1));
            enable       = ($urandom_range(15) != 0);
            if ($urandom_range(63) == 0) arb_mode = ~arb_mode;
            rst = ($urandom_range(399) == 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
